// File: rtl/mem_pkg.sv
// Shared widths, responder state encoding and parity helper for the memory responder.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 5;
    localparam int unsigned MEM_DATA_W = 8;
    localparam int unsigned MEM_CNT_W  = 16;

    // Bit 0 marks a read response and bit 1 a protocol error, so status outputs are plain flop bits
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RESP = 2'b01,
        ERR  = 2'b10
    } resp_state_e;

    // Even-parity bit: makes the total count of ones (data plus bit) even
    function automatic logic parity(input logic [MEM_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-bus responder: register-file memory with registered read response,
// protocol-error detection and saturating counters. Optional MEM_PARITY_EN adds per-word parity.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned CNT_W  = MEM_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rvalid,
    output logic              proto_err,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  err_cnt
`ifdef MEM_PARITY_EN
    ,
    input  logic              inj_par,
    output logic              par_err
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    resp_state_e       state;
    logic              rd_only;
    logic              wr_only;
    logic              rd_wr;

    assign rd_only = read & ~write;
    assign wr_only = write & ~read;
    assign rd_wr   = read & write;

    // Array, read register and response FSM; conflicting strobes perform no access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_out <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= IDLE;
            if (rd_only) begin
                data_out <= mem[addr];
                state    <= RESP;
            end else if (wr_only) begin
                mem[addr] <= data_in;
            end else if (rd_wr) begin
                state <= ERR;
            end
        end
    end

    assign rvalid    = state[0];
    assign proto_err = state[1];

`ifdef MEM_PARITY_EN
    logic mem_par [DEPTH];

    // Parity flag is registered alongside data_out so it lines up with rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_par[i] <= 1'b0;
            end
        end else begin
            par_err <= rd_only && (parity(MEM_DATA_W'(mem[addr])) != mem_par[addr]);
            if (wr_only) begin
                mem_par[addr] <= parity(MEM_DATA_W'(data_in)) ^ inj_par;
            end
        end
    end
`endif

    sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_only),
        .count (rd_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_only),
        .count (wr_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_wr),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: scoreboard of read data plus a vector table
// for protocol corner cases. Parity checks are included when MEM_PARITY_EN is defined.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  addr = '0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        rvalid;
    logic        proto_err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic [15:0] err_cnt;
`ifdef MEM_PARITY_EN
    logic        inj_par = 1'b0;
    logic        par_err;
`endif

    always #5 clk = ~clk;

    mem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .rvalid    (rvalid),
        .proto_err (proto_err),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .err_cnt   (err_cnt)
`ifdef MEM_PARITY_EN
        ,
        .inj_par   (inj_par),
        .par_err   (par_err)
`endif
    );

    typedef struct {
        bit         r;
        bit         w;
        logic [4:0] a;
        logic [7:0] d;
        bit         e_rv;
        bit         e_pe;
        logic [7:0] e_dout;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_mem [32];
    bit          model_bad [32];
    logic [15:0] m_rd, m_wr, m_err;
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_dout;
    bit          exp_par;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            model_mem[i] = 8'h00;
            model_bad[i] = 1'b0;
        end
        m_rd = '0; m_wr = '0; m_err = '0;
        exp_q.delete();
        exp_dout = 8'h00;
        exp_par = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One bus cycle: drive at negedge, let one rising edge pass, compare at next negedge
    task automatic step(input bit r, input bit w, input logic [4:0] a, input logic [7:0] d,
                        input bit inj, input bit cnt_chk);
        read = r; write = w; addr = a; data_in = d;
`ifdef MEM_PARITY_EN
        inj_par = inj;
`endif
        @(posedge clk);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
`ifdef MEM_PARITY_EN
        inj_par = 1'b0;
`endif
        exp_par = 1'b0;
        if (r && !w) begin
            exp_q.push_back(model_mem[a]);
            exp_par = model_bad[a];
            m_rd = sat_inc(m_rd);
        end
        if (w && !r) begin
            model_mem[a] = d;
            model_bad[a] = inj;
            m_wr = sat_inc(m_wr);
        end
        if (r && w) m_err = sat_inc(m_err);

        check("rvalid", 32'(rvalid), 32'(r && !w));
        check("proto_err", 32'(proto_err), 32'(r && w));
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: rvalid with no read outstanding");
            end else begin
                exp_dout = exp_q.pop_front();
            end
        end
        check("data_out", 32'(data_out), 32'(exp_dout));
`ifdef MEM_PARITY_EN
        check("par_err", 32'(par_err), 32'(exp_par));
`endif
        if (cnt_chk) begin
            check("rd_cnt", 32'(rd_cnt), 32'(m_rd));
            check("wr_cnt", 32'(wr_cnt), 32'(m_wr));
            check("err_cnt", 32'(err_cnt), 32'(m_err));
        end
    endtask

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 5'd7,  8'h55, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 5'd7,  8'h00, 1'b1, 1'b0, 8'h55};
        tbl[2]  = '{1'b1, 1'b1, 5'd7,  8'hFF, 1'b0, 1'b1, 8'h55};
        tbl[3]  = '{1'b1, 1'b0, 5'd7,  8'h00, 1'b1, 1'b0, 8'h55};
        tbl[4]  = '{1'b0, 1'b1, 5'd8,  8'h99, 1'b0, 1'b0, 8'h55};
        tbl[5]  = '{1'b1, 1'b0, 5'd8,  8'h00, 1'b1, 1'b0, 8'h99};
        tbl[6]  = '{1'b1, 1'b0, 5'd7,  8'h00, 1'b1, 1'b0, 8'h55};
        tbl[7]  = '{1'b0, 1'b0, 5'd7,  8'h00, 1'b0, 1'b0, 8'h55};
        tbl[8]  = '{1'b1, 1'b1, 5'd0,  8'h12, 1'b0, 1'b1, 8'h55};
        tbl[9]  = '{1'b1, 1'b1, 5'd0,  8'h34, 1'b0, 1'b1, 8'h55};
        tbl[10] = '{1'b1, 1'b0, 5'd31, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 5'd31, 8'hAB, 1'b0, 1'b0, 8'h00};
        tbl[12] = '{1'b1, 1'b0, 5'd31, 8'h00, 1'b1, 1'b0, 8'hAB};

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted while a write to addr 3 is on the bus
        step(1'b0, 1'b1, 5'd3, 8'h11, 1'b0, 1'b1);
        read = 1'b0; write = 1'b1; addr = 5'd3; data_in = 8'hA5;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        rst_n = 1'b1;
        model_reset();
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        step(1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b1);
        check("rst_addr3", 32'(data_out), 32'h00);

        // data == addr, then 32 back-to-back reads
        reset_dut();
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 5'(i), 8'(i), 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 5'(i), 8'h00, 1'b0, 1'b1);
            check("seq_read", 32'(data_out), 32'(i));
        end
        check("seq_wr_cnt", 32'(wr_cnt), 32'd32);
        check("seq_rd_cnt", 32'(rd_cnt), 32'd32);

        // Random printable ASCII fill and readback
        for (int i = 0; i < 32; i++)
            step(1'b0, 1'b1, 5'(i), 8'($urandom_range(32'h7A, 32'h41)), 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 5'(i), 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b1);

        // Protocol-error and ordering corner cases from the vector table
        reset_dut();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, 1'b1);
            check($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].e_rv));
            check($sformatf("vec%0d_proto_err", i), 32'(proto_err), 32'(tbl[i].e_pe));
            check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(tbl[i].e_dout));
        end
        check("vec_err_cnt", 32'(err_cnt), 32'd3);
        check("vec_rd_cnt", 32'(rd_cnt), 32'd6);
        check("vec_wr_cnt", 32'(wr_cnt), 32'd3);

        // Write-counter saturation
        reset_dut();
        for (int i = 0; i < 65540; i++)
            step(1'b0, 1'b1, 5'(i), 8'(i), 1'b0, (i < 4) || (i > 65530));
        check("sat_wr_cnt", 32'(wr_cnt), 32'h0000FFFF);
        check("sat_rd_cnt", 32'(rd_cnt), 32'd0);

`ifdef MEM_PARITY_EN
        // Injected parity fault is flagged with rvalid; data still returned
        reset_dut();
        step(1'b0, 1'b1, 5'd9, 8'h3C, 1'b1, 1'b1);
        step(1'b1, 1'b0, 5'd9, 8'h00, 1'b0, 1'b1);
        check("par_inj_data", 32'(data_out), 32'h3C);
        check("par_inj_flag", 32'(par_err), 32'd1);
        step(1'b0, 1'b1, 5'd10, 8'h3C, 1'b0, 1'b1);
        step(1'b1, 1'b0, 5'd10, 8'h00, 1'b0, 1'b1);
        check("par_clean_flag", 32'(par_err), 32'd0);
`endif

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
